seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display, built on the existing hex glyph decoder.
- Holds a double-buffered hex word, scans one digit per slot, and inserts an anti-ghosting blank at the start of each slot.
- Adds per-digit decimal point, per-digit blanking and leading-zero suppression.
- Sits between the CPU/register interface and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, CLK cycles per digit slot (>= BLANK_CYC+2).
- BLANK_CYC, 64, cycles at the start of each slot with all digits off (>= 1).

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- nRST  in  1  reset: asynchronous assert, active-low.
- DATA  in  4*DIGITS  hex nibbles; nibble i = DATA[4i+3:4i], digit 0 = least significant.
- DP  in  DIGITS  decimal point request per digit, active-high.
- BLANK  in  DIGITS  force digit i dark, active-high.
- LZ_SUPPRESS  in  1  enable leading-zero suppression.
- LOAD  in  1  one-cycle strobe; captures DATA, DP and BLANK.
- nSEG  out  8  active-low segments; bit7 = dp, bits6..0 = g..a.
- nDIG  out  DIGITS  active-low digit enables; at most one low.
- FRAME  out  1  one-cycle pulse when a new scan frame starts.

Behaviour:
- Reset (nRST low, asynchronous):
  - slot counter = 0, digit index = 0, FRAME = 0.
  - Pending and active buffers = 0, pend_valid = 0.
  - nSEG = 8'hFF, nDIG = all 1.
- Prescaler:
  - Counter runs 0..PRESCALE-1, then wraps to 0.
  - At PRESCALE-1 the index advances; DIGITS-1 wraps to 0.
  - FRAME is high for exactly the cycle in which the index becomes 0; after reset it is not asserted until the first wrap.
- Double buffer:
  - LOAD copies DATA/DP/BLANK into pending and sets pend_valid.
  - When the index becomes 0 and pend_valid = 1, pending is copied to active and pend_valid clears.
  - If LOAD coincides with the wrap, the incoming DATA/DP/BLANK go straight to active and pend_valid stays 0.
  - Multiple LOADs within one frame: the last one wins.
  - The display shows only active, so no frame ever mixes old and new values.
- Glyphs (hex, dp off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:D8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - DP[i] = 1 clears bit7.
- Leading-zero suppression, only when LZ_SUPPRESS = 1:
  - Digit i (i >= 1) is dark if nibbles i..DIGITS-1 of active are all zero.
  - Digit 0 is never suppressed.
  - A suppressed or BLANKed digit drives nSEG = 8'hFF, DP included.
- Slot output:
  - Counter < BLANK_CYC: nDIG all 1, nSEG = FF.
  - Otherwise: nDIG[index] = 0 and nSEG = glyph of the current digit.
  - BLANKed and suppressed digits still assert nDIG, so brightness stays uniform.
- Latency:
  - nSEG and nDIG are registered, one cycle after the counter/index state that selects them.
  - FRAME is registered and aligned to nDIG.
  - LZ_SUPPRESS is sampled live, not buffered.
- Invariants:
  - nDIG never has more than one bit low.
  - When nDIG changes the active digit there is always at least BLANK_CYC cycles of all-1 between the two digits.

Test Plan:
(Parameters for all scenarios: DIGITS=4, PRESCALE=4, BLANK_CYC=1.)
1. Reset, then LOAD DATA=16'h1234, DP=0, BLANK=0 → after the next FRAME the digits show:
   - nDIG=1110 with nSEG=99 (4).
   - nDIG=1101 with nSEG=B0 (3).
   - nDIG=1011 with nSEG=A4 (2).
   - nDIG=0111 with nSEG=F9 (1).
   - Each digit for 3 cycles, separated by 1 cycle of nDIG=1111 / nSEG=FF.
   - FRAME pulses every 16 cycles.
2. LOAD 16'hABCD, then LOAD 16'hEF01 mid-frame → the current frame still shows the old data; the next frame shows EF01:
   - digit0 nSEG=F9.
   - digit3 nSEG=86.
   - ABCD is never displayed.
3. LOAD asserted in the same cycle the index wraps to 0, DATA=16'h0007 → that frame's digit 0 shows D8 immediately.
4. DATA=16'h0070, LZ_SUPPRESS=1:
   - digits 3 and 2 show FF with their nDIG still asserted in turn.
   - digit1 = D8, digit0 = C0.
   - With DATA=0, only digit0 shows C0.
5. DP=4'b0010, BLANK=4'b1000, DATA=16'h8888:
   - digit1 nSEG=00.
   - digit3 nSEG=FF.
   - digits 0 and 2 nSEG=80.
6. Drop nRST mid-slot, asynchronously between clock edges:
   - nSEG=FF, nDIG=1111 and FRAME=0 immediately.
   - After release, the first digit is lit at the cycle after counter=BLANK_CYC, showing digit 0 with active=0 (C0).

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with a double-buffered
// hex word, per-digit dp/blank, leading-zero suppression and inter-slot blanking.
module seven_seg_scan #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLANK,
  input  logic                  LZ_SUPPRESS,
  input  logic                  LOAD,
  output logic [7:0]            nSEG,
  output logic [DIGITS-1:0]     nDIG,
  output logic                  FRAME
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_data, act_data;
  logic [DIGITS-1:0]     pend_dp, pend_blank, act_dp, act_blank;
  logic                  pend_valid;
  logic                  new_frame;

  logic                  slot_end, frame_wrap;
  logic [3:0]            nib;
  logic                  dp_sel, blank_sel, upper_nz, dark;
  logic [DIGITS-1:0]     dig_sel;
  logic [7:0]            seg_sel;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;  4'h7: glyph = 8'hD8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A LOAD landing on the frame wrap bypasses pending so it shows this frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else if (frame_wrap) begin
      pend_valid <= 1'b0;
      if (LOAD) begin
        act_data  <= DATA;
        act_dp    <= DP;
        act_blank <= BLANK;
      end else if (pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
    end else if (LOAD) begin
      pend_data  <= DATA;
      pend_dp    <= DP;
      pend_blank <= BLANK;
      pend_valid <= 1'b1;
    end
  end

  // upper_nz: any nonzero nibble at or above the digit being scanned.
  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    upper_nz  = 1'b0;
    dig_sel   = '1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (idx == IW'(j)) begin
        nib        = act_data[4*j +: 4];
        dp_sel     = act_dp[j];
        blank_sel  = act_blank[j];
        dig_sel[j] = 1'b0;
      end
      if ((IW'(j) >= idx) && (act_data[4*j +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    dark    = blank_sel || (LZ_SUPPRESS && (idx != '0) && !upper_nz);
    seg_sel = dark ? 8'hFF : (glyph(nib) & ~{dp_sel, 7'b0});
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      nSEG      <= 8'hFF;
      nDIG      <= '1;
      FRAME     <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      new_frame <= frame_wrap;
      FRAME     <= new_frame;
      if (cnt < CNT_BLANK) begin
        nSEG <= 8'hFF;
        nDIG <= '1;
      end else begin
        nSEG <= seg_sel;
        nDIG <= dig_sel;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed scoreboard bench for seven_seg_scan (DIGITS=4, PRESCALE=4, BLANK_CYC=1).
module tb_seven_seg_scan;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] DATA = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  BLANK = '0;
  logic        LZ_SUPPRESS = 1'b0;
  logic        LOAD = 1'b0;
  logic [7:0]  nSEG;
  logic [3:0]  nDIG;
  logic        FRAME;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  seven_seg_scan #(.DIGITS(4), .PRESCALE(4), .BLANK_CYC(1)) dut (
    .CLK(CLK), .nRST(nRST), .DATA(DATA), .DP(DP), .BLANK(BLANK),
    .LZ_SUPPRESS(LZ_SUPPRESS), .LOAD(LOAD), .nSEG(nSEG), .nDIG(nDIG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // At most one digit enable may be low at any time.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      checks++;
      assert ($countones(~nDIG) <= 1) else begin
        errors++;
        $error("FAIL ndig_onehot observed=%b expected=at_most_one_low", nDIG);
      end
    end
  end

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back(s0);
    exp_q.push_back(s1);
    exp_q.push_back(s2);
    exp_q.push_back(s3);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (FRAME !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("frame_wait", {7'b0, FRAME}, 8'h01);
  endtask

  // Starts on the FRAME sample; ends on the following frame's FRAME sample.
  // Optional LOADs are driven after the check at sample ka / kb.
  task automatic scan_frame(input int ka, input logic [15:0] da,
                            input int kb, input logic [15:0] db);
    logic [7:0] e;
    logic [3:0] ed;
    int s;
    int p;
    e = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      s = k / 4;
      p = k % 4;
      if (p == 1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL scoreboard_empty observed=0 expected=entry");
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end
      ed = 4'hF;
      if (p != 0) ed[s] = 1'b0;
      check("ndig", {4'b0, nDIG}, {4'b0, ed});
      check("nseg", nSEG, (p == 0) ? 8'hFF : e);
      check("frame", {7'b0, FRAME}, {7'b0, (k == 0)});
      if (k == ka) begin
        DATA = da;
        LOAD = 1'b1;
      end else if (k == kb) begin
        DATA = db;
        LOAD = 1'b1;
      end else begin
        LOAD = 1'b0;
      end
      tick();
    end
    check("frame_period", {7'b0, FRAME}, 8'h01);
  endtask

  initial begin
    #1 nRST = 1'b0;
    repeat (3) tick();
    check("rst_nseg", nSEG, 8'hFF);
    check("rst_ndig", {4'b0, nDIG}, 8'h0F);
    check("rst_frame", {7'b0, FRAME}, 8'h00);
    nRST = 1'b1;
    tick();
    DATA = 16'h1234;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;

    // Basic scan of 1234, twice to confirm the 16-cycle frame period.
    wait_frame();
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    scan_frame(-1, 16'h0, -1, 16'h0);
    // Two mid-frame LOADs: this frame stays 1234, next shows only the last.
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    scan_frame(2, 16'hABCD, 6, 16'hEF01);
    // LOAD coinciding with the wrap goes straight to the next frame.
    push_frame(8'hF9, 8'hC0, 8'h8E, 8'h86);
    scan_frame(14, 16'h0007, -1, 16'h0);
    // LOAD just after the wrap lands in pending for one whole frame.
    push_frame(8'hD8, 8'hC0, 8'hC0, 8'hC0);
    scan_frame(15, 16'h0070, -1, 16'h0);
    push_frame(8'hD8, 8'hC0, 8'hC0, 8'hC0);
    scan_frame(-1, 16'h0, -1, 16'h0);
    // Leading-zero suppression on 0070, then on all-zero data.
    LZ_SUPPRESS = 1'b1;
    push_frame(8'hC0, 8'hD8, 8'hFF, 8'hFF);
    scan_frame(5, 16'h0000, -1, 16'h0);
    DP = 4'b0010;
    BLANK = 4'b1000;
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    scan_frame(3, 16'h8888, -1, 16'h0);
    // Decimal point and forced blank.
    push_frame(8'h80, 8'h00, 8'h80, 8'hFF);
    scan_frame(-1, 16'h0, -1, 16'h0);

    // Asynchronous reset between clock edges while digit 0 is lit.
    tick();
    tick();
    check("pre_rst_ndig", {4'b0, nDIG}, 8'h0E);
    #2 nRST = 1'b0;
    #1;
    check("async_nseg", nSEG, 8'hFF);
    check("async_ndig", {4'b0, nDIG}, 8'h0F);
    check("async_frame", {7'b0, FRAME}, 8'h00);
    tick();
    nRST = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("post_rst_frame", {7'b0, FRAME}, 8'h00);
      if (i == 1) begin
        check("post_rst_blank_ndig", {4'b0, nDIG}, 8'h0F);
        check("post_rst_blank_nseg", nSEG, 8'hFF);
      end else if (i <= 4) begin
        check("post_rst_ndig", {4'b0, nDIG}, 8'h0E);
        check("post_rst_nseg", nSEG, 8'hC0);
      end
    end
    tick();
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    scan_frame(-1, 16'h0, -1, 16'h0);

    check("scoreboard_left", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
